video_render_multi: RTL and testbench

//  Renders fetched 64-bit video words into a 4-bit pixel stream. Supports

---
 rtl/video_render_multi.sv | 131 +++++++++++++
 tb/tb_video_render_multi.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/video_render_multi.sv
// video_render_multi: 64-bit fetch word to 4-bit pixel renderer (ZX/hicolor/16c).
// Optional border/blank inputs enabled by defining VIDEO_RENDER_BORDER_EN.
module video_render_multi #(
    parameter int FLASH_BITS = 5,
    parameter int OUT_REG    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pic_bits,
    input  logic        fetch_sync,
    input  logic        cend,
    input  logic        int_start,
    input  logic [1:0]  mode,
`ifdef VIDEO_RENDER_BORDER_EN
    input  logic        blank,
    input  logic [2:0]  border,
`endif
    output logic [3:0]  pixels
);

    logic [63:0]           r_shadow;
    logic [1:0]            r_mode;
    logic [3:0]            r_pixnum;
    logic [FLASH_BITS-1:0] r_flash_ctr;
    logic                  r_flash;
    logic [FLASH_BITS-1:0] w_ctr_inc;
    logic                  w_flash_nxt;
    logic [7:0]            w_pixbyte;
    logic [7:0]            w_attr;
    logic [7:0]            w_cbyte;
    logic                  w_bit;
    logic [3:0]            w_pix;
    logic [3:0]            w_render;

    assign w_ctr_inc   = r_flash_ctr + 1'b1;
    assign w_flash_nxt = int_start ? w_ctr_inc[FLASH_BITS-1]
                                   : r_flash_ctr[FLASH_BITS-1];

    // Group latch and pixel counter, advanced only on the pixel strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_mode   <= 2'b00;
            r_pixnum <= 4'd0;
            r_flash  <= 1'b0;
        end else if (cend) begin
            r_flash <= w_flash_nxt;
            if (fetch_sync) begin
                r_shadow <= pic_bits;
                r_mode   <= mode;
                r_pixnum <= 4'd0;
            end else begin
                r_pixnum <= r_pixnum + 4'd1;
            end
        end
    end

    // Frame counter driving the flash phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flash_ctr <= '0;
        end else if (int_start) begin
            r_flash_ctr <= w_ctr_inc;
        end
    end

    // Pixel decode from the shadow word for the current pixel number
    always_comb begin
        w_pixbyte = r_pixnum[3] ? r_shadow[15:8]  : r_shadow[7:0];
        w_attr    = r_pixnum[3] ? r_shadow[31:24] : r_shadow[23:16];
        w_cbyte   = r_shadow[8*r_pixnum[3:1] +: 8];
        w_bit     = w_pixbyte[~r_pixnum[2:0]] ^ (r_flash & w_attr[7]);
        case (r_mode)
            2'b10: begin
                w_pix = r_pixnum[0]
                      ? {w_cbyte[7], w_cbyte[5:3]}
                      : {w_cbyte[6], w_cbyte[2:0]};
            end
            default: begin
                w_pix = w_bit
                      ? {w_attr[6], w_attr[2:0]}
                      : {w_attr[6], w_attr[5:3]};
            end
        endcase
    end

`ifdef VIDEO_RENDER_BORDER_EN
    logic       r_blank;
    logic [2:0] r_border;

    // Blank/border sampled per pixel so they share the pixel latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank  <= 1'b0;
            r_border <= 3'd0;
        end else if (cend) begin
            r_blank  <= blank;
            r_border <= border;
        end
    end

    assign w_render = r_blank ? {1'b0, r_border} : w_pix;
`else
    assign w_render = w_pix;
`endif

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic       r_cend_d;
            logic [3:0] r_pixels;

            // Output register loads one clock after each pixel strobe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cend_d <= 1'b0;
                    r_pixels <= 4'h0;
                end else begin
                    r_cend_d <= cend;
                    if (r_cend_d) begin
                        r_pixels <= w_render;
                    end
                end
            end

            assign pixels = r_pixels;
        end else begin : g_comb
            assign pixels = w_render;
        end
    endgenerate

endmodule

// File: tb/tb_video_render_multi.sv
// tb_video_render_multi: scoreboard bench for video_render_multi.
// Directed groups with hand-computed pixel nibbles, pixel 0 in the top nibble.
module tb_video_render_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pic_bits;
    logic        fetch_sync;
    logic        cend;
    logic        int_start;
    logic [1:0]  mode;
    logic        blank;
    logic [2:0]  border;
    logic [3:0]  pixels;

    int total = 0;
    int bad = 0;
    logic [3:0] q[$];

    localparam logic [63:0] W_ZX  = 64'h0000_0000_1647_0FA5;
    localparam logic [63:0] E_ZX  = 64'hF8F8_8F8F_2222_6666;
    localparam logic [63:0] W_FL  = 64'h0000_0000_C7C7_00A5;
    localparam logic [63:0] E_FL0 = 64'hF8F8_8F8F_8888_8888;
    localparam logic [63:0] E_FL1 = 64'h8F8F_F8F8_FFFF_FFFF;
    localparam logic [63:0] W_16  = 64'h5538_0780_40FF_00D3;
    localparam logic [63:0] E_16  = 64'hBA00_FF80_0870_07D2;
    localparam logic [63:0] E_BD  = 64'h5555_8F8F_2222_6666;

    always #5 clk = ~clk;

    video_render_multi dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pic_bits   (pic_bits),
        .fetch_sync (fetch_sync),
        .cend       (cend),
        .int_start  (int_start),
        .mode       (mode),
`ifdef VIDEO_RENDER_BORDER_EN
        .blank      (blank),
        .border     (border),
`endif
        .pixels     (pixels)
    );

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: output is valid one clock after each strobe
    initial begin
        forever begin
            @(posedge clk);
            if (cend === 1'b1 && rst_n === 1'b1) begin
                @(posedge clk);
                #1;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pix_unexpected: got %h want none", pixels);
                end else begin
                    check("pix", pixels, q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic fs, input logic [3:0] exp,
                        input logic is);
        cend = 1'b1;
        fetch_sync = fs;
        int_start = is;
        q.push_back(exp);
        @(negedge clk);
        cend = 1'b0;
        fetch_sync = 1'b0;
        int_start = 1'b0;
        if (fs) pic_bits = 64'hDEAD_BEEF_0123_4567;
        repeat (3) @(negedge clk);
    endtask

    task automatic group(input logic [63:0] w, input logic [1:0] m,
                         input logic [1:0] m_after, input logic [63:0] e,
                         input int reps, input logic is0,
                         input logic stray);
        pic_bits = w;
        mode = m;
        for (int i = 0; i < 16 * reps; i++) begin
            if (i == 1) mode = m_after;
            if (stray && i == 5) begin
                fetch_sync = 1'b1;
                @(negedge clk);
                fetch_sync = 1'b0;
            end
            step(i == 0, e[63-4*(i%16) -: 4], is0 && i == 0);
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            int_start = 1'b1;
            @(negedge clk);
            int_start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pic_bits = W_ZX;
        fetch_sync = 1'b1;
        cend = 1'b0;
        int_start = 1'b0;
        mode = 2'b00;
        blank = 1'b0;
        border = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cend = ~cend;
            #1;
            check("reset_pix", pixels, 4'h0);
        end
        @(negedge clk);
        cend = 1'b0;
        fetch_sync = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_pix", pixels, 4'h0);

        group(W_ZX, 2'b00, 2'b00, E_ZX, 1, 1'b0, 1'b0);
        group(W_ZX, 2'b11, 2'b11, E_ZX, 1, 1'b0, 1'b0);
        group(W_16, 2'b10, 2'b00, E_16, 1, 1'b0, 1'b0);
        group(W_ZX, 2'b00, 2'b00, E_ZX, 1, 1'b0, 1'b0);
        group(W_ZX, 2'b00, 2'b00, E_ZX, 2, 1'b0, 1'b1);

        pulses(15);
        group(W_FL, 2'b00, 2'b00, E_FL1, 1, 1'b1, 1'b0);
        pulses(16);
        group(W_FL, 2'b00, 2'b00, E_FL0, 1, 1'b0, 1'b0);

`ifdef VIDEO_RENDER_BORDER_EN
        pic_bits = W_ZX;
        mode = 2'b00;
        border = 3'd5;
        for (int i = 0; i < 16; i++) begin
            blank = (i < 4);
            step(i == 0, E_BD[63-4*i -: 4], 1'b0);
        end
        blank = 1'b0;
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
